// File: rtl/ship_key_tracker.sv
// PS/2 ship-key tracker: held-key mask, prioritised ship_control code, rate-limited fire pulse.
// Optional ARROW_KEYS_EN maps E0-prefixed arrow keys onto the movement bits.
module ship_key_tracker #(
    parameter int unsigned FIRE_COOLDOWN = 5000000,
    parameter int unsigned SEQ_TIMEOUT   = 250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       code_valid,
    input  logic [7:0] code,
    output logic [4:0] held,
    output logic [3:0] ship_control,
    output logic       fire_pulse,
    output logic       seq_error
);

    localparam int unsigned CD_W = (FIRE_COOLDOWN > 2) ? $clog2(FIRE_COOLDOWN) : 1;
    localparam int unsigned TO_W = (SEQ_TIMEOUT > 2) ? $clog2(SEQ_TIMEOUT) : 1;
    localparam logic [7:0]  BRK_CODE = 8'hF0;
    localparam logic [7:0]  EXT_CODE = 8'hE0;

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    state_t            state;
    state_t            state_n;
    logic [4:0]        base_q;
    logic [4:0]        base_n;
    logic [4:0]        held_n;
    logic [3:0]        ctrl_n;
    logic              fire_c;
    logic              timeout_c;
    logic [CD_W-1:0]   cd_cnt;
    logic [CD_W-1:0]   cd_n;
    logic [TO_W-1:0]   to_cnt;
    logic [TO_W-1:0]   to_n;

    function automatic logic [4:0] base_mask(input logic [7:0] c);
        case (c)
            8'h1C:   base_mask = 5'b00001;
            8'h23:   base_mask = 5'b00010;
            8'h1B:   base_mask = 5'b00100;
            8'h1D:   base_mask = 5'b01000;
            8'h29:   base_mask = 5'b10000;
            default: base_mask = 5'b00000;
        endcase
    endfunction

    function automatic logic [3:0] ctrl_of(input logic [4:0] h);
        if (h[3])      ctrl_of = 4'd4;
        else if (h[0]) ctrl_of = 4'd1;
        else if (h[1]) ctrl_of = 4'd2;
        else if (h[2]) ctrl_of = 4'd3;
        else           ctrl_of = 4'd5;
    endfunction

`ifdef ARROW_KEYS_EN
    logic [3:0] ext_q;
    logic [3:0] ext_n;

    function automatic logic [3:0] ext_mask(input logic [7:0] c);
        case (c)
            8'h6B:   ext_mask = 4'b0001;
            8'h74:   ext_mask = 4'b0010;
            8'h72:   ext_mask = 4'b0100;
            8'h75:   ext_mask = 4'b1000;
            default: ext_mask = 4'b0000;
        endcase
    endfunction
`endif

    // Counter reaches SEQ_TIMEOUT-1 on this edge with no byte arriving
    assign timeout_c = (state != IDLE) && !code_valid && (to_cnt == TO_W'(SEQ_TIMEOUT - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (code_valid) begin
            case (state)
                IDLE: begin
                    if (code == BRK_CODE)      state_n = BRK;
                    else if (code == EXT_CODE) state_n = EXT;
                end
                EXT:     state_n = (code == BRK_CODE) ? EXT_BRK : IDLE;
                default: state_n = IDLE;
            endcase
        end else if (timeout_c) begin
            state_n = IDLE;
        end
    end

    always_comb begin
        base_n = base_q;
`ifdef ARROW_KEYS_EN
        ext_n  = ext_q;
`endif
        if (code_valid) begin
            case (state)
                IDLE:    base_n = base_q | base_mask(code);
                BRK:     base_n = base_q & ~base_mask(code);
`ifdef ARROW_KEYS_EN
                EXT:     if (code != BRK_CODE) ext_n = ext_q | ext_mask(code);
                EXT_BRK: ext_n = ext_q & ~ext_mask(code);
`endif
                default: ;
            endcase
        end
`ifdef ARROW_KEYS_EN
        held_n = base_n | {1'b0, ext_n};
`else
        held_n = base_n;
`endif
        ctrl_n = ctrl_of(held_n);
        // Release in the same cycle as cooldown expiry suppresses the pulse
        fire_c = held_n[4] && (cd_cnt == '0);
        if (fire_c)            cd_n = CD_W'(FIRE_COOLDOWN - 1);
        else if (cd_cnt != '0) cd_n = cd_cnt - CD_W'(1);
        else                   cd_n = cd_cnt;
        if ((state == IDLE) || code_valid || timeout_c) to_n = '0;
        else                                            to_n = to_cnt + TO_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q       <= '0;
            held         <= '0;
            ship_control <= 4'd5;
            fire_pulse   <= 1'b0;
            seq_error    <= 1'b0;
            cd_cnt       <= '0;
            to_cnt       <= '0;
        end else begin
            base_q       <= base_n;
            held         <= held_n;
            ship_control <= ctrl_n;
            fire_pulse   <= fire_c;
            seq_error    <= timeout_c;
            cd_cnt       <= cd_n;
            to_cnt       <= to_n;
        end
    end

`ifdef ARROW_KEYS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ext_q <= '0;
        else        ext_q <= ext_n;
    end
`endif

endmodule

// File: tb/tb_ship_key_tracker.sv
// Directed bench for ship_key_tracker: vector table for key tracking plus timed fire/timeout/reset sequences.
module tb_ship_key_tracker;

    localparam int unsigned FC = 8;
    localparam int unsigned TO = 16;
`ifdef ARROW_KEYS_EN
    localparam logic ARROW = 1'b1;
`else
    localparam logic ARROW = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       code_valid = 1'b0;
    logic [7:0] code = 8'h00;
    logic [4:0] held;
    logic [3:0] ship_control;
    logic       fire_pulse;
    logic       seq_error;

    int checks = 0;
    int errors = 0;

    ship_key_tracker #(.FIRE_COOLDOWN(FC), .SEQ_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .code(code),
        .held(held), .ship_control(ship_control), .fire_pulse(fire_pulse), .seq_error(seq_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       valid;
        logic [7:0] code;
        logic [4:0] held;
        logic [3:0] ctrl;
    } vec_t;

    vec_t vecs[23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the byte's effect visible
    task automatic put(input logic v, input logic [7:0] b);
        code_valid = v;
        code       = b;
        @(negedge clk);
        code_valid = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [7:0] b);
        code_valid = v;
        code       = b;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 8'h1D, 5'b01000, 4'd4};
        vecs[1]  = '{1'b1, 8'h1C, 5'b01001, 4'd4};
        vecs[2]  = '{1'b1, 8'hF0, 5'b01001, 4'd4};
        vecs[3]  = '{1'b1, 8'h1D, 5'b00001, 4'd1};
        vecs[4]  = '{1'b1, 8'h23, 5'b00011, 4'd1};
        vecs[5]  = '{1'b1, 8'h1C, 5'b00011, 4'd1};
        vecs[6]  = '{1'b1, 8'hF0, 5'b00011, 4'd1};
        vecs[7]  = '{1'b1, 8'h1C, 5'b00010, 4'd2};
        vecs[8]  = '{1'b1, 8'h1B, 5'b00110, 4'd2};
        vecs[9]  = '{1'b1, 8'hF0, 5'b00110, 4'd2};
        vecs[10] = '{1'b1, 8'h23, 5'b00100, 4'd3};
        vecs[11] = '{1'b0, 8'h23, 5'b00100, 4'd3};
        vecs[12] = '{1'b1, 8'h55, 5'b00100, 4'd3};
        vecs[13] = '{1'b1, 8'hF0, 5'b00100, 4'd3};
        vecs[14] = '{1'b1, 8'h1B, 5'b00000, 4'd5};
        vecs[15] = '{1'b1, 8'hF0, 5'b00000, 4'd5};
        vecs[16] = '{1'b1, 8'h55, 5'b00000, 4'd5};
        vecs[17] = '{1'b1, 8'h1B, 5'b00100, 4'd3};
        vecs[18] = '{1'b1, 8'h1D, 5'b01100, 4'd4};
        vecs[19] = '{1'b1, 8'hF0, 5'b01100, 4'd4};
        vecs[20] = '{1'b1, 8'h1D, 5'b00100, 4'd3};
        vecs[21] = '{1'b1, 8'hF0, 5'b00100, 4'd3};
        vecs[22] = '{1'b1, 8'h1B, 5'b00000, 4'd5};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_held", 32'(held), 32'd0);
        check("reset_ctrl", 32'(ship_control), 32'd5);
        check("reset_fire", 32'(fire_pulse), 32'd0);
        check("reset_seqerr", 32'(seq_error), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Key tracking and priority table
        for (int i = 0; i < 23; i++) begin
            put(vecs[i].valid, vecs[i].code);
            check($sformatf("vec%0d_held", i), 32'(held), 32'(vecs[i].held));
            check($sformatf("vec%0d_ctrl", i), 32'(ship_control), 32'(vecs[i].ctrl));
            check($sformatf("vec%0d_fire", i), 32'(fire_pulse), 32'd0);
        end

        // Auto-repeat fire: pulses at cycles 1, 9, 17, 25; release at 30/31 stops it
        put(1'b1, 8'h29);
        for (int c = 1; c <= 40; c++) begin
            check($sformatf("autofire_c%0d", c), 32'(fire_pulse),
                  32'((c == 1) || (c == 9) || (c == 17) || (c == 25)));
            if (c == 2)  check("autofire_held_on", 32'(held[4]), 32'd1);
            if (c == 33) check("autofire_held_off", 32'(held[4]), 32'd0);
            if (c == 30)      drive(1'b1, 8'hF0);
            else if (c == 31) drive(1'b1, 8'h29);
            else              drive(1'b0, 8'h00);
            @(negedge clk);
        end

        // Typematic repeats: one pulse in the first cooldown window
        put(1'b1, 8'h29);
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("typematic_c%0d", c), 32'(fire_pulse), 32'(c == 1));
            if (c < 3) drive(1'b1, 8'h29);
            else       drive(1'b0, 8'h00);
            @(negedge clk);
        end
        check("typematic_held", 32'(held), 32'b10000);
        put(1'b1, 8'hF0);
        put(1'b1, 8'h29);
        repeat (10) @(negedge clk);

        // Re-press during cooldown fires only when the counter drains
        put(1'b1, 8'h29);
        for (int c = 1; c <= 10; c++) begin
            check($sformatf("cooldown_c%0d", c), 32'(fire_pulse), 32'((c == 1) || (c == 9)));
            if (c == 1)      drive(1'b1, 8'hF0);
            else if (c == 2) drive(1'b1, 8'h29);
            else if (c == 3) drive(1'b1, 8'h29);
            else             drive(1'b0, 8'h00);
            @(negedge clk);
        end
        put(1'b1, 8'hF0);
        put(1'b1, 8'h29);
        repeat (10) @(negedge clk);
        check("cooldown_released", 32'(held), 32'd0);

        // Break within the timeout window still applies
        put(1'b1, 8'h1C);
        put(1'b1, 8'hF0);
        repeat (10) begin
            check("late_break_noerr", 32'(seq_error), 32'd0);
            @(negedge clk);
        end
        put(1'b1, 8'h1C);
        check("late_break_held", 32'(held), 32'd0);

        // Abandoned F0: seq_error 16 cycles later, next byte is a make
        put(1'b1, 8'hF0);
        for (int c = 1; c <= 20; c++) begin
            check($sformatf("timeout_c%0d", c), 32'(seq_error), 32'(c == 16));
            @(negedge clk);
        end
        check("timeout_held_kept", 32'(held), 32'd0);
        put(1'b1, 8'h1C);
        check("timeout_then_make", 32'(held), 32'b00001);
        put(1'b1, 8'hF0);
        put(1'b1, 8'h1C);
        check("timeout_cleanup", 32'(held), 32'd0);

        // Extended prefix: arrow keys share bits with base keys
        put(1'b1, 8'hE0);
        put(1'b1, 8'h6B);
        check("ext_make_left", 32'(held), 32'(ARROW ? 5'b00001 : 5'b00000));
        put(1'b1, 8'h1C);
        check("ext_base_left", 32'(held), 32'b00001);
        put(1'b1, 8'hE0);
        put(1'b1, 8'hF0);
        put(1'b1, 8'h6B);
        check("ext_break_keeps_base", 32'(held), 32'b00001);
        put(1'b1, 8'hF0);
        put(1'b1, 8'h1C);
        check("base_break_clears", 32'(held), 32'd0);
        check("base_break_ctrl", 32'(ship_control), 32'd5);
        put(1'b1, 8'hE0);
        put(1'b1, 8'h75);
        check("ext_thrust_ctrl", 32'(ship_control), 32'(ARROW ? 4'd4 : 4'd5));
        put(1'b1, 8'h1C);
        put(1'b1, 8'hF0);
        put(1'b1, 8'h1C);
        put(1'b1, 8'hE0);
        put(1'b1, 8'hF0);
        put(1'b1, 8'h75);
        check("ext_all_released", 32'(held), 32'd0);

        // Async reset mid-sequence discards the pending break
        put(1'b1, 8'h1D);
        put(1'b1, 8'hF0);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_held", 32'(held), 32'd0);
        check("midreset_ctrl", 32'(ship_control), 32'd5);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        put(1'b1, 8'h1D);
        check("after_reset_make", 32'(held), 32'b01000);
        check("after_reset_ctrl", 32'(ship_control), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
